// File: rtl/uart_echo_fifo_if.sv
// uart_echo_fifo_if: byte bus between UART receiver, echo FIFO and transmitter.
// master drives the receiver side and tx_done; slave is the echo FIFO.
interface uart_echo_fifo_if;
   logic [7:0] rx_data;
   logic       rx_done;
   logic [7:0] tx_data;
   logic       send_en;
   logic       tx_done;

   modport master (
      output rx_data, rx_done, tx_done,
      input  tx_data, send_en
   );

   modport slave (
      input  rx_data, rx_done, tx_done,
      output tx_data, send_en
   );
endinterface

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: circular byte FIFO from UART rx to UART tx with send FSM.
// Optional match LED toggle is enabled by defining UART_ECHO_LED_EN.
module uart_echo_fifo #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_W     = 4,
   parameter logic [7:0]  MATCH_BYTE = 8'h69
) (
   input  logic            clk,
   input  logic            rst_n,
   uart_echo_fifo_if.slave bus,
   input  logic            ovf_clr,
   output logic [ADDR_W:0] fifo_count,
   output logic            empty,
   output logic            full,
   output logic            overflow,
   output logic            led
);

   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_GAP
   } state_t;

   logic [7:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_rx_done_d;
   logic              r_ovf;
   logic              r_send_en;
   logic [7:0]        r_tx_data;
   state_t            r_state;

   logic w_wr_req;
   logic w_full;
   logic w_wr_ok;
   logic w_drop;
   logic w_rd;

   assign w_wr_req = bus.rx_done & ~r_rx_done_d;
   assign w_full   = (r_count == LP_DEPTH);
   assign w_wr_ok  = w_wr_req & ~w_full;
   assign w_drop   = w_wr_req & w_full;
   assign w_rd     = (r_state == S_LOAD);

   // rx_done delay for rising-edge write detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rx_done_d <= 1'b0;
      else        r_rx_done_d <= bus.rx_done;
   end

   // storage array, contents need no reset
   always_ff @(posedge clk) begin
      if (w_wr_ok) r_mem[r_wr_ptr] <= bus.rx_data;
   end

   // write pointer advances only on accepted bytes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_wr_ptr <= '0;
      else if (w_wr_ok) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
   end

   // occupancy: simultaneous write and read cancel out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         unique case ({w_wr_ok, w_rd})
            2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
            2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // sticky overflow, a fresh drop beats a clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_ovf <= 1'b0;
      else if (w_drop)  r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
   end

   // transmit FSM: pop one byte, hold send_en until tx_done, then gap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_rd_ptr  <= '0;
         r_tx_data <= 8'h00;
         r_send_en <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (r_count != '0) r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_tx_data <= r_mem[r_rd_ptr];
               r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
               r_send_en <= 1'b1;
               r_state   <= S_SEND;
            end
            S_SEND: begin
               if (bus.tx_done) begin
                  r_send_en <= 1'b0;
                  r_state   <= S_GAP;
               end
            end
            S_GAP: begin
               r_send_en <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.tx_data = r_tx_data;
   assign bus.send_en = r_send_en;
   assign fifo_count  = r_count;
   assign empty       = (r_count == '0);
   assign full        = w_full;
   assign overflow    = r_ovf;

`ifdef UART_ECHO_LED_EN
   logic r_led;

   // toggle on every accepted byte equal to MATCH_BYTE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_led <= 1'b0;
      else if (w_wr_ok && (bus.rx_data == MATCH_BYTE))
         r_led <= ~r_led;
   end

   assign led = r_led;
`else
   logic w_unused_match;
   assign w_unused_match = ^MATCH_BYTE;
   assign led = 1'b0;
`endif

endmodule
